sd_win_accum: RTL and testbench

//  Producer side of the sum/saturation-count interface used by the feedback mean filter.

---
 rtl/sd_win_accum.sv | 117 +++++++++++
 tb/tb_sd_win_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_win_accum.sv
// Window accumulator: sums WIN serial pixels and counts saturated ones, then holds
// the completed window (s, Nslt, ovf11) until downstream takes it with win_ready.
module sd_win_accum #(
  parameter int PIX_W   = 8,
  parameter int WIN     = 9,
  parameter int SAT_VAL = 255,
  parameter int SUM_W   = 12,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [SUM_W-1:0] s,
  output logic [CNT_W-1:0] Nslt,
  output logic             ovf11,
  output logic             win_valid,
  input  logic             win_ready
);

  // state | meaning
  // ACC   | accumulating pixels of the current window, idx = pixels taken so far
  // HOLD  | window complete, s/Nslt/ovf11 frozen until win_ready
  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [PIX_W-1:0] SAT_PIX  = PIX_W'(SAT_VAL);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIN - 1);
  localparam logic [SUM_W-1:0] OVF_LIM  = SUM_W'(2047);

  state_t state, state_nxt;

  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;

  logic             accept;
  logic             is_sat;
  logic             last;
  logic [SUM_W-1:0] pix_ext;
  logic [CNT_W-1:0] sat_ext;
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_sum;

  assign pix_ready = (state == ACC) || (state == HOLD && win_ready);
  assign accept    = pix_valid && pix_ready;
  assign is_sat    = (pix_in == SAT_PIX);
  assign last      = (idx == IDX_LAST);
  assign pix_ext   = SUM_W'(pix_in);
  assign sat_ext   = CNT_W'(is_sat);
  assign acc_sum   = acc + pix_ext;
  assign cnt_sum   = cnt + sat_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (!flush && accept && last) state_nxt = HOLD;
      HOLD: if (win_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      s         <= '0;
      Nslt      <= '0;
      ovf11     <= 1'b0;
      win_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (flush) begin
            acc <= '0;
            cnt <= '0;
            idx <= '0;
          end else if (accept) begin
            if (last) begin
              s         <= acc_sum;
              Nslt      <= cnt_sum;
              ovf11     <= (acc_sum > OVF_LIM);
              win_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              idx       <= '0;
            end else begin
              acc <= acc_sum;
              cnt <= cnt_sum;
              idx <= idx + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // flush is ignored here so the finished window is still delivered
          if (win_ready) begin
            win_valid <= 1'b0;
            if (accept) begin
              acc <= pix_ext;
              cnt <= sat_ext;
              idx <= CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_win_accum.sv
// Bench for sd_win_accum: a queue-based window model checked every cycle, plus
// hand-computed window results for the directed scenarios.
module tb_sd_win_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [11:0] s;
  logic [3:0]  Nslt;
  logic        ovf11;
  logic        win_valid;
  logic        win_ready;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: pixels of the open window, plus the last delivered window result
  logic [7:0] m_q[$];
  bit         m_pend = 1'b0;
  int         m_s = 0;
  int         m_n = 0;
  int         m_o = 0;

  sd_win_accum dut (
    .clk(clk), .rst(rst), .flush(flush), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .s(s), .Nslt(Nslt), .ovf11(ovf11),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = 1'b0;
    m_s = 0;
    m_n = 0;
    m_o = 0;
  endtask

  task automatic model_step();
    bit took;
    int sum;
    int n;
    took = pix_valid && (!m_pend || win_ready);
    if (rst) begin
      model_reset();
    end else if (m_pend) begin
      if (win_ready) begin
        m_pend = 1'b0;
        if (took) m_q.push_back(pix_in);
      end
    end else if (flush) begin
      m_q.delete();
    end else if (took) begin
      m_q.push_back(pix_in);
      if (m_q.size() == 9) begin
        sum = 0;
        n = 0;
        foreach (m_q[i]) begin
          sum += int'(m_q[i]);
          if (m_q[i] == 8'd255) n++;
        end
        m_s = sum;
        m_n = n;
        m_o = (sum > 2047) ? 1 : 0;
        m_pend = 1'b1;
        m_q.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("win_valid", int'(win_valid), int'(m_pend));
      chk("pix_ready", int'(pix_ready), int'(!m_pend || win_ready));
      chk("s", int'(s), m_s);
      chk("Nslt", int'(Nslt), m_n);
      chk("ovf11", int'(ovf11), m_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] p);
    bit took;
    int waited;
    pix_in = p;
    pix_valid = 1'b1;
    waited = 0;
    do begin
      took = pix_ready;
      tick();
      waited++;
    end while (!took && waited < 50);
    pix_valid = 1'b0;
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", p, waited);
    end
  endtask

  task automatic lit(input string tag, input int es, input int en, input int eo);
    chk({tag, "_valid"}, int'(win_valid), 1);
    chk({tag, "_s"}, int'(s), es);
    chk({tag, "_Nslt"}, int'(Nslt), en);
    chk({tag, "_ovf11"}, int'(ovf11), eo);
  endtask

  task automatic do_reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_s"}, int'(s), 0);
    chk({tag, "_Nslt"}, int'(Nslt), 0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] t3 [9];
    t3 = '{8'd255, 8'd0, 8'd255, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd254};
    rst = 1'b1;
    flush = 1'b0;
    pix_in = '0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_s", int'(s), 0);
    chk("rst_Nslt", int'(Nslt), 0);
    chk("rst_ovf11", int'(ovf11), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk_en = 1'b1;

    // 1: nine 10s, single-cycle win_valid
    for (int i = 0; i < 9; i++) send(8'd10);
    lit("t1", 90, 0, 0);
    tick();
    chk("t1_pulse", int'(win_valid), 0);

    // 2: all saturated
    for (int i = 0; i < 9; i++) send(8'd255);
    lit("t2", 2295, 9, 1);
    chk("t2_removed", int'(s) - int'(Nslt) * 255, 0);
    tick();

    // 3: mixed values with random stalls
    for (int i = 0; i < 9; i++) begin
      send(t3[i]);
      if (i < 8) idle($urandom_range(0, 2));
    end
    lit("t3", 779, 2, 0);
    tick();

    // 4: backpressure, then handshake with a pixel in the same cycle
    win_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'd20);
    pix_in = 8'd7;
    pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_pix_ready", int'(pix_ready), 0);
      lit("t4_hold", 180, 0, 0);
      tick();
    end
    win_ready = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("t4_released", int'(win_valid), 0);
    for (int i = 0; i < 8; i++) send(8'd3);
    lit("t4_next", 31, 0, 0);
    tick();

    // 5: flush drops four saturated pixels and the pixel offered with it
    for (int i = 0; i < 4; i++) send(8'd255);
    flush = 1'b1;
    pix_in = 8'd255;
    pix_valid = 1'b1;
    tick();
    flush = 1'b0;
    pix_valid = 1'b0;
    for (int i = 0; i < 9; i++) send(8'd1);
    lit("t5", 9, 0, 0);
    tick();

    // 6: reset mid-window and during HOLD
    for (int i = 0; i < 5; i++) send(8'd50);
    do_reset_check("t6_mid");
    for (int i = 0; i < 9; i++) send(8'd2);
    lit("t6_fresh", 18, 0, 0);
    win_ready = 1'b0;
    tick();
    do_reset_check("t6_hold");
    win_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(8'd4);
    lit("t6_after", 36, 0, 0);
    idle(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
